// File: rtl/mac_window_drain.sv
// Splits a free-running MAC cumulative sum into windows of N valid beats and
// queues each window's shifted, saturated difference for a valid/ready consumer.
module mac_window_drain #(
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT      = 0,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [ACC_WIDTH-1:0] i_acc_val,
    input  logic                 i_acc_valid,
    input  logic [CNT_WIDTH-1:0] i_win_len,
    output logic [OUT_WIDTH-1:0] o_val,
    output logic                 o_sat,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = ACC_WIDTH + OUT_WIDTH;
    localparam int DW = OUT_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Returns {sat, result}; the wide extension keeps the range test valid for any width ratio.
    function automatic logic [DW-1:0] scale_sat(input logic [ACC_WIDTH-1:0] diff);
        logic [EW-1:0] ext;
        ext = EW'(diff >> SHIFT);
        if ((ext >> OUT_WIDTH) != EW'(0)) begin
            scale_sat = {1'b1, {OUT_WIDTH{1'b1}}};
        end else begin
            scale_sat = {1'b0, ext[OUT_WIDTH-1:0]};
        end
    endfunction

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [ACC_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0] len_eff_s;
    logic                 final_s;

    logic [DW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW:0]          fill_q, fill_d;
    logic                 ovf_q, ovf_d;
    logic                 pop_s, push_s, full_s;
    logic [DW-1:0]        entry_s;

    assign len_eff_s = (i_win_len == CNT_WIDTH'(0)) ? CNT_WIDTH'(1) : i_win_len;
    assign entry_s   = scale_sat(i_acc_val - base_q);

    // Window FSM: beat counting, final-beat detection and base tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        final_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_acc_valid) begin
                    len_d = len_eff_s;
                    cnt_d = CNT_WIDTH'(1);
                    if (len_eff_s == CNT_WIDTH'(1)) begin
                        final_s = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (i_acc_valid) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_d == len_q) begin
                        final_s = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (final_s) begin
            base_d = i_acc_val;
        end else begin
            base_d = base_q;
        end
    end

    // FIFO control; a push into a full FIFO is only accepted alongside a pop.
    always_comb begin
        pop_s  = (fill_q != (AW+1)'(0)) && i_ready;
        full_s = (fill_q == (AW+1)'(FIFO_DEPTH));
        push_s = final_s && (!full_s || pop_s);
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        if (push_s) begin
            wr_d = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        if (push_s && !pop_s) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            fill_d = fill_q - (AW+1)'(1);
        end else begin
            fill_d = fill_q;
        end
        if (final_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_WIDTH'(0);
            len_q   <= CNT_WIDTH'(0);
            base_q  <= ACC_WIDTH'(0);
            wr_q    <= AW'(0);
            rd_q    <= AW'(0);
            fill_q  <= (AW+1)'(0);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result storage; cleared so o_val/o_sat read zero straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= DW'(0);
            end
        end else if (push_s) begin
            mem_q[wr_q] <= entry_s;
        end
    end

    assign o_val      = mem_q[rd_q][OUT_WIDTH-1:0];
    assign o_sat      = mem_q[rd_q][OUT_WIDTH];
    assign o_valid    = (fill_q != (AW+1)'(0));
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q == ST_COUNT);

endmodule

// File: tb/tb_mac_window_drain.sv
// Directed, table-driven self-checking bench for mac_window_drain.
module tb_mac_window_drain;

    logic        clk;
    logic        rst_n;
    logic [39:0] acc_val;
    logic        acc_valid;
    logic [15:0] win_len;
    logic [31:0] val;
    logic        sat;
    logic        valid;
    logic        ready;
    logic        overflow;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic [39:0] acc;
        logic [15:0] len;
        logic [31:0] exp_val;
        logic        exp_sat;
    } vec_t;

    vec_t tbl [8];

    localparam logic [39:0] B = 40'h02_0000_002F;

    mac_window_drain dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_acc_val   (acc_val),
        .i_acc_valid (acc_valid),
        .i_win_len   (win_len),
        .o_val       (val),
        .o_sat       (sat),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_overflow  (overflow),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [39:0] v, input logic [15:0] l);
        acc_val   = v;
        win_len   = l;
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] v, input logic s, input logic vld);
        chk({name, "_valid"}, 64'(valid), 64'(vld));
        if (vld) begin
            chk({name, "_val"}, 64'(val), 64'(v));
            chk({name, "_sat"}, 64'(sat), 64'(s));
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_val"},  64'(val), 64'd0);
        chk({name, "_sat"},  64'(sat), 64'd0);
        chk({name, "_valid"}, 64'(valid), 64'd0);
        chk({name, "_ovf"},  64'(overflow), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        acc_val   = 40'd0;
        acc_valid = 1'b0;
        win_len   = 16'd0;
        ready     = 1'b1;

        tbl[0] = '{40'h00_0000_0000, 16'd1, 32'hFFFF_FFFF, 1'b1};
        tbl[1] = '{40'h01_0000_0005, 16'd1, 32'hFFFF_FFFF, 1'b1};
        tbl[2] = '{40'h01_0000_0009, 16'd1, 32'h0000_0004, 1'b0};
        tbl[3] = '{40'hFF_FFFF_FFF0, 16'd1, 32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{40'h00_0000_0010, 16'd1, 32'h0000_0020, 1'b0};
        tbl[5] = '{40'h00_0000_0030, 16'd0, 32'h0000_0020, 1'b0};
        tbl[6] = '{40'h01_0000_002F, 16'd1, 32'hFFFF_FFFF, 1'b0};
        tbl[7] = '{40'h02_0000_002F, 16'd1, 32'hFFFF_FFFF, 1'b1};

        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // len=4 window 10,30,60,100
        beat(40'd10, 16'd4);
        chk("w4_busy1", 64'(busy), 64'd1);
        chk("w4_novalid1", 64'(valid), 64'd0);
        beat(40'd30, 16'd4);
        beat(40'd60, 16'd4);
        chk("w4_busy3", 64'(busy), 64'd1);
        chk("w4_novalid3", 64'(valid), 64'd0);
        beat(40'd100, 16'd4);
        chk("w4_busy4", 64'(busy), 64'd0);
        chk_out("w4", 32'd100, 1'b0, 1'b1);
        tick();
        chk("w4_popped", 64'(valid), 64'd0);

        // len=2 with gaps, then len=0
        beat(40'd150, 16'd2);
        tick();
        tick();
        chk("w2_gap_busy", 64'(busy), 64'd1);
        chk("w2_gap_novalid", 64'(valid), 64'd0);
        beat(40'd220, 16'd2);
        chk_out("w2", 32'd120, 1'b0, 1'b1);
        tick();
        beat(40'd225, 16'd0);
        chk("w0_busy", 64'(busy), 64'd0);
        chk_out("w0", 32'd5, 1'b0, 1'b1);
        tick();

        // single-beat windows: saturation, wrap, boundaries
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].acc, tbl[i].len);
            chk_out($sformatf("tbl%0d", i), tbl[i].exp_val, tbl[i].exp_sat, 1'b1);
            tick();
            chk($sformatf("tbl%0d_drained", i), 64'(valid), 64'd0);
        end

        // backpressure: five results into a 4-deep FIFO
        ready = 1'b0;
        beat(B + 40'd1, 16'd1);
        chk_out("bp1", 32'd1, 1'b0, 1'b1);
        beat(B + 40'd3, 16'd1);
        beat(B + 40'd6, 16'd1);
        beat(B + 40'd10, 16'd1);
        chk("bp_no_ovf_yet", 64'(overflow), 64'd0);
        beat(B + 40'd15, 16'd1);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk_out("bp_stable", 32'd1, 1'b0, 1'b1);
        tick();
        chk_out("bp_stable2", 32'd1, 1'b0, 1'b1);
        ready = 1'b1;
        beat(B + 40'd21, 16'd1);
        chk_out("bp_d2", 32'd2, 1'b0, 1'b1);
        tick();
        chk_out("bp_d3", 32'd3, 1'b0, 1'b1);
        tick();
        chk_out("bp_d4", 32'd4, 1'b0, 1'b1);
        tick();
        chk_out("bp_full_push", 32'd6, 1'b0, 1'b1);
        tick();
        chk("bp_empty", 64'(valid), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);

        // asynchronous reset mid-window with results queued
        ready = 1'b0;
        beat(B + 40'd22, 16'd1);
        beat(B + 40'd24, 16'd1);
        beat(B + 40'd30, 16'd4);
        beat(B + 40'd40, 16'd4);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        chk_out("rst_pre", 32'd1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        beat(40'd7, 16'd1);
        chk_out("post_rst", 32'd7, 1'b0, 1'b1);
        chk("post_rst_ovf", 64'(overflow), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
